// File: rtl/tug_input_stage.sv
// Tug-of-war input front end: debounced human key pulse plus LFSR-paced CPU opponent.
// Define TUG_CPU_PLAYER_EN to build the CPU player; otherwise cpu_press and lfsr_q are tied to 0.
module tug_input_stage #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CPU_PERIOD      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic       cpu_en,
  input  logic [8:0] difficulty,
  input  logic       game_over,
  output logic       human_press,
  output logic       cpu_press,
  output logic [9:0] lfsr_q
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  deb_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             press_accept;

  // s1/s2 hold the pressed level (inverted key) so the FSM works in positive logic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~key_raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_accept = 1'b0;
    case (state)
      RELEASED: begin
        if (s2) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = PRESSED;
          cnt_next     = '0;
          press_accept = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM keeps tracking during game_over; only the pulse is masked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      human_press <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      human_press <= press_accept & ~game_over;
    end
  end

`ifdef TUG_CPU_PLAYER_EN
  localparam int unsigned DIV_W = $clog2(CPU_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CPU_PERIOD - 1);

  logic [9:0]       lfsr;
  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick   = (div == DIV_LAST);
  assign lfsr_q = lfsr;

  // decision compares against the pre-edge LFSR value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= 10'h3FF;
      div       <= '0;
      cpu_press <= 1'b0;
    end else begin
      lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      div       <= tick ? '0 : div + DIV_W'(1);
      cpu_press <= tick & cpu_en & ~game_over & ({1'b0, difficulty} > lfsr);
    end
  end
`else
  localparam int unsigned cpu_period_unused = CPU_PERIOD;
  logic cpu_unused;

  assign cpu_unused = ^{cpu_en, difficulty};
  assign cpu_press  = 1'b0;
  assign lfsr_q     = '0;
`endif

endmodule
